// File: rtl/pong_pkg.sv
// Shared Pong definitions: default button count, button channel indices
// and the default game-tick period.
package pong_pkg;

    localparam int unsigned N_BTN_DEFAULT    = 4;
    localparam int unsigned TICK_DIV_DEFAULT = 100011;

    // Button channel indices into btn_n / btn_level / btn_press / ...
    typedef enum int unsigned {
        BTN_P1_UP = 0,
        BTN_P1_DN = 1,
        BTN_P2_UP = 2,
        BTN_P2_DN = 3
    } btn_idx_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce counter, debounced level,
// press/release pulses, hold-on-tick flag and optional auto-repeat.
//
// Configuration macro: BTN_AUTOREPEAT_EN (adds tick-based auto-repeat).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   btn_n         raw active-low button pin (asynchronous to clk)
//   tick_pre      high in the cycle before the registered game tick
//   level         debounced pressed state (active-high)
//   press         one-cycle pulse on accepted press (and repeats)
//   release_pulse one-cycle pulse on accepted release
//   hold_tick     level & tick, aligned with the registered tick
module btn_debounce_ch
    import pong_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 30,
    parameter int unsigned REPEAT_RATE     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    input  logic tick_pre,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic hold_tick
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("btn_debounce_ch: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_chk_rpt
        $error("btn_debounce_ch: REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   accept;
    logic                   rise, fall;
    logic                   rpt_fire;
    logic                   press_q, release_q, hold_q;

    // Synchroniser resets to the released (pin high) state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
        end
    end

    assign synced = ~sync_q[SYNC_STAGES-1];

    // Counter only runs while the synced input disagrees with the accepted
    // state; any agreement (a bounce) drops it straight back to zero.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        accept   = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                accept   = 1'b1;
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign rise = accept & synced;
    assign fall = accept & ~synced;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;

    // Counts ticks strictly after the accepted press; the first interval is
    // REPEAT_DELAY ticks, later ones REPEAT_RATE. A tick landing on the
    // acceptance cycle itself is not counted.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = 1'b0;
        if (rise || !stable_d) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (stable_q && tick_pre) begin
            if (rpt_cnt_q == (rpt_first_q ? RPT_W'(REPEAT_DELAY - 1)
                                          : RPT_W'(REPEAT_RATE - 1))) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= rise | rpt_fire;
            release_q <= fall;
            hold_q    <= tick_pre & stable_d;
        end
    end

    assign level         = stable_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign hold_tick     = hold_q;

endmodule

// File: rtl/pong_input_conditioner.sv
// Pong input conditioner: debounces the active-low push buttons, produces
// clean levels and press/release pulses, and generates the game tick.
//
// Configuration macro: BTN_AUTOREPEAT_EN (auto-repeat btn_press pulses on
// held buttons, paced by the game tick).
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   btn_n         raw active-low buttons
//   btn_level     debounced pressed state
//   btn_press     one-cycle pulse per accepted press (plus repeats)
//   btn_release   one-cycle pulse per accepted release
//   all_released  registered AND of ~btn_level
//   tick          one-cycle game-tick strobe every TICK_DIV cycles
//   btn_hold_tick btn_level & tick, aligned with tick
module pong_input_conditioner
    import pong_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT,
    parameter int unsigned REPEAT_DELAY    = 30,
    parameter int unsigned REPEAT_RATE     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             all_released,
    output logic             tick,
    output logic [N_BTN-1:0] btn_hold_tick
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);

    if (TICK_DIV < 2) begin : g_chk_tick
        $error("pong_input_conditioner: TICK_DIV must be at least 2");
    end

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick_pre;
    logic              tick_q;
    logic              all_rel_q;

    assign tick_pre = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_pre ? '0 : tick_cnt_q + 1'b1;
            tick_q     <= tick_pre;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .btn_n         (btn_n[i]),
            .tick_pre      (tick_pre),
            .level         (btn_level[i]),
            .press         (btn_press[i]),
            .release_pulse (btn_release[i]),
            .hold_tick     (btn_hold_tick[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_rel_q <= 1'b1;
        end else begin
            all_rel_q <= ~|btn_level;
        end
    end

    assign tick         = tick_q;
    assign all_released = all_rel_q;

endmodule

// File: tb/tb_pong_input_conditioner.sv
module tb_pong_input_conditioner;
    import pong_pkg::*;

    localparam int unsigned NB  = 4;
    localparam int unsigned TDV = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_n = '1;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold_tick;
    logic          all_released, tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    // Reference cycle count since reset release; expected tick derives from it.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic exp_tick();
        return (cyc != 0) && (cyc % TDV == 0);
    endfunction

    pong_input_conditioner #(
        .N_BTN           (NB),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .TICK_DIV        (TDV),
        .REPEAT_DELAY    (3),
        .REPEAT_RATE     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .all_released  (all_released),
        .tick          (tick),
        .btn_hold_tick (btn_hold_tick)
    );

    task automatic test_reset();
        int ticks_seen = 0;
        rst   = 1'b1;
        btn_n = '1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({btn_level, btn_press, btn_release, btn_hold_tick, all_released, tick}
            !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: lvl=%b prs=%b rel=%b hold=%b allrel=%b tick=%b expected 0/0/0/0/1/0",
                     btn_level, btn_press, btn_release, btn_hold_tick, all_released, tick);
        end
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (tick !== ((k % 10) == 0)) begin
                n_fail++;
                $display("FAIL tick_period k=%0d: tick=%b expected %b", k, tick, (k % 10) == 0);
            end
            if (tick === 1'b1) ticks_seen++;
            n_checks++;
            if (btn_level !== 4'b0000 || all_released !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_levels k=%0d: lvl=%b allrel=%b expected 0000/1", k, btn_level, all_released);
            end
        end
        n_checks++;
        if (ticks_seen != 3) begin
            n_fail++;
            $display("FAIL tick_count: got %0d expected 3", ticks_seen);
        end
    endtask

    task automatic test_press();
        btn_n[BTN_P1_UP] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn_level[0] !== (k >= 10) || btn_press[0] !== (k == 10) || btn_release[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL press0 k=%0d: lvl=%b prs=%b rel=%b expected %b/%b/0",
                         k, btn_level[0], btn_press[0], btn_release[0], k >= 10, k == 10);
            end
            n_checks++;
            if (all_released !== (k < 11)) begin
                n_fail++;
                $display("FAIL allrel_press k=%0d: got %b expected %b", k, all_released, k < 11);
            end
        end
        btn_n[BTN_P1_UP] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn_level[0] !== (k < 10) || btn_release[0] !== (k == 10) || btn_press[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL release0 k=%0d: lvl=%b rel=%b prs=%b expected %b/%b/0",
                         k, btn_level[0], btn_release[0], btn_press[0], k < 10, k == 10);
            end
        end
    endtask

    task automatic test_bounce();
        btn_n[BTN_P1_DN] = 1'b0;
        repeat (5) @(negedge clk);
        btn_n[BTN_P1_DN] = 1'b1;
        @(negedge clk);
        btn_n[BTN_P1_DN] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn_level[1] !== (k >= 10) || btn_press[1] !== (k == 10)) begin
                n_fail++;
                $display("FAIL bounce1 k=%0d: lvl=%b prs=%b expected %b/%b",
                         k, btn_level[1], btn_press[1], k >= 10, k == 10);
            end
        end
        btn_n[BTN_P1_DN] = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (btn_level[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce1_release: lvl=%b expected 0", btn_level[1]);
        end
    endtask

    task automatic test_hold_tick();
        btn_n[BTN_P2_UP] = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn_hold_tick !== {1'b0, exp_tick(), 2'b00} || tick !== exp_tick()) begin
                n_fail++;
                $display("FAIL hold_tick k=%0d: hold=%b tick=%b expected %b/%b",
                         k, btn_hold_tick, tick, {1'b0, exp_tick(), 2'b00}, exp_tick());
            end
        end
        btn_n[BTN_P2_UP] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn_level[2] !== (k < 10) || btn_release[2] !== (k == 10) || all_released !== (k >= 11)) begin
                n_fail++;
                $display("FAIL release2 k=%0d: lvl=%b rel=%b allrel=%b expected %b/%b/%b",
                         k, btn_level[2], btn_release[2], all_released, k < 10, k == 10, k >= 11);
            end
            n_checks++;
            if (btn_hold_tick[2] !== (exp_tick() && (k < 10))) begin
                n_fail++;
                $display("FAIL hold_release k=%0d: hold2=%b expected %b", k, btn_hold_tick[2], exp_tick() && (k < 10));
            end
        end
    endtask

    task automatic test_reset_mid();
        btn_n[BTN_P2_DN] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({btn_level, btn_press, btn_release, btn_hold_tick, all_released, tick}
            !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: lvl=%b prs=%b rel=%b hold=%b allrel=%b tick=%b expected 0/0/0/0/1/0",
                     btn_level, btn_press, btn_release, btn_hold_tick, all_released, tick);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (btn_press !== 4'b0000 || btn_release !== 4'b0000 || btn_level !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: prs=%b rel=%b lvl=%b expected 0000", btn_press, btn_release, btn_level);
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn_level[3] !== (k >= 10) || btn_press[3] !== (k == 10) || tick !== (k == 10)) begin
                n_fail++;
                $display("FAIL repress3 k=%0d: lvl=%b prs=%b tick=%b expected %b/%b/%b",
                         k, btn_level[3], btn_press[3], tick, k >= 10, k == 10, k == 10);
            end
        end
        btn_n[BTN_P2_DN] = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (btn_level !== 4'b0000 || all_released !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after3: lvl=%b allrel=%b expected 0000/1", btn_level, all_released);
        end
    endtask

    task automatic test_repeat();
        int  ticks_after = 0;
        bit  pressed     = 0;
        logic exp_p;
        btn_n[BTN_P1_UP] = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            exp_p = 1'b0;
            if (k == 10) begin
                exp_p = 1'b1;
            end else if (pressed && exp_tick()) begin
                ticks_after++;
`ifdef BTN_AUTOREPEAT_EN
                exp_p = (ticks_after >= 3) && (((ticks_after - 3) % 2) == 0);
`endif
            end
            if (k == 10) pressed = 1;
            n_checks++;
            if (btn_press[0] !== exp_p) begin
                n_fail++;
                $display("FAIL repeat0 k=%0d ticks=%0d: prs=%b expected %b", k, ticks_after, btn_press[0], exp_p);
            end
        end
        btn_n[BTN_P1_UP] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn_release[0] !== (k == 10)) begin
                n_fail++;
                $display("FAIL repeat_release k=%0d: rel=%b expected %b", k, btn_release[0], k == 10);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_hold_tick();
        test_reset_mid();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_input_conditioner.md
# pong_input_conditioner

Upstream conditioning stage for the Pong game-logic block. Synchronises and debounces the four active-low push buttons, emits clean pressed levels and one-cycle press/release pulses, and generates the game-tick strobe that paces paddle and ball motion. Game logic consumes only this block's outputs; it never reads raw button pins or runs its own divider.

## Interface
- N_BTN, 4: number of button channels.
- SYNC_STAGES, 2: synchroniser flops per channel (min 2).
- DEBOUNCE_CYCLES, 500000: consecutive stable synced cycles needed to accept a change (10 ms at 50 MHz); min 2.
- TICK_DIV, 100011: game-tick period in clk cycles; min 2.
- REPEAT_DELAY, 30: ticks held before first auto-repeat (BTN_AUTOREPEAT_EN only).
- REPEAT_RATE, 8: ticks between subsequent repeats (BTN_AUTOREPEAT_EN only).
- clk  in  1  system clock (50 MHz board clock). One clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_n  in  N_BTN  raw buttons, active-low, asynchronous to clk.
- btn_level  out  N_BTN  debounced pressed state, active-high.
- btn_press  out  N_BTN  one-cycle pulse on accepted press (plus repeats if enabled).
- btn_release  out  N_BTN  one-cycle pulse on accepted release.
- all_released  out  1  registered AND of ~btn_level.
- tick  out  1  one-cycle game-tick strobe.
- btn_hold_tick  out  N_BTN  btn_level & tick, registered in the same cycle as tick.

## Operation
- Per channel: SYNC_STAGES-flop synchroniser on btn_n, inverted to active-high `synced`.
- Debounce counter per channel, width $clog2(DEBOUNCE_CYCLES): while synced == stable, counter held at 0; while synced != stable, counter increments; when counter == DEBOUNCE_CYCLES-1 and still differing, stable <= synced, counter <= 0.
- A bounce (synced returns to stable) before the terminal count clears the counter; no partial credit.
- btn_press asserted in the same cycle stable goes 0->1; btn_release in the same cycle stable goes 1->0. Never both in one cycle on one channel.
- Tick divider: counter 0..TICK_DIV-1, wraps to 0; tick = 1 in the cycle after counter == TICK_DIV-1 (registered). Free-running; unaffected by buttons.
- btn_hold_tick[i] = 1 exactly in cycles where tick = 1 and btn_level[i] = 1.
- Channels are fully independent; simultaneous changes on any set of channels are handled in parallel.

## Timing
- Reset values: sync flops 1 (released), stable 0, all counters 0, btn_level 0, btn_press 0, btn_release 0, tick 0, btn_hold_tick 0, all_released 1.
- Pin-to-level latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from the first clk edge sampling the new pin value, assuming no bounce.
- First tick: TICK_DIV cycles after rst deasserts; then every TICK_DIV cycles exactly.
- all_released lags btn_level by one cycle.
- Reset mid-debounce or mid-hold: all state returns to reset values immediately; no press/release pulse is generated by the reset itself. A button still held after reset is re-accepted as a fresh press after the normal latency.

## Configuration
- BTN_AUTOREPEAT_EN defined: per-channel repeat counter (tick-based). After btn_press, once REPEAT_DELAY ticks have elapsed while held, btn_press pulses coincident with tick; thereafter every REPEAT_RATE ticks until release. Release or reset clears the repeat counter.
- Not defined: btn_press fires only on the accepted 0->1 edge. REPEAT_* parameters are ignored, and no repeat logic is synthesised.

## Structure
- Shared package pong_pkg: N_BTN default, button index constants BTN_P1_UP=0, BTN_P1_DN=1, BTN_P2_UP=2, BTN_P2_DN=3, and default TICK_DIV.
- One sub-module: btn_debounce_ch (synchroniser, debounce counter, level/press/release, optional repeat), instantiated N_BTN times by generate. Tick divider and all_released live in the top level.

## Test plan
Bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, TICK_DIV=10, REPEAT_DELAY=3, REPEAT_RATE=2.
- Reset, all btn_n=1: all outputs at reset values; tick first high at cycle 10 after rst falls, then at 20, 30.
- btn_n[0] falls and stays low: btn_level[0] rises and btn_press[0] pulses once, 10 cycles later; btn_release stays 0.
- btn_n[1] low for 5 cycles, high 1 cycle, then low: no early acceptance; level rises 8 stable cycles after the last edge plus sync delay.
- Hold btn 2 across ticks: btn_hold_tick[2] high exactly on tick cycles; release gives one btn_release[2] pulse, and all_released returns to 1 one cycle after btn_level.
- Assert rst mid-debounce on btn 3: counters clear, no pulses; after rst falls with btn still held, press is accepted after 10 cycles.
- With BTN_AUTOREPEAT_EN and btn 0 held: initial press, then extra btn_press pulses on the 3rd tick after the press and every 2nd tick thereafter; without the macro, exactly one press.
